// File: rtl/dff_pipe_pkg.sv
// Shared constants and elaboration-time parameter checks for the dff_pipe register chain.
package dff_pipe_pkg;

    localparam int unsigned DFF_PIPE_DEF_WIDTH = 1;
    localparam int unsigned DFF_PIPE_DEF_DEPTH = 1;

    // Legal when there is at least one bit and one stage, and the reset value fits the data width.
    function automatic logic chk_params(
        input int unsigned width,
        input int unsigned depth,
        input int unsigned rst_bits
    );
        return (width >= 1) && (depth >= 1) && (rst_bits <= width);
    endfunction

endpackage

// File: rtl/dff_pipe_if.sv
// Data bus of the register chain: the driver pushes din and reads dout back.
interface dff_pipe_if
    import dff_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = DFF_PIPE_DEF_WIDTH
);

    typedef logic [WIDTH-1:0] data_t;

    data_t din;
    data_t dout;

    modport master (output din, input dout);
    modport slave  (input din, output dout);

endinterface

// File: rtl/dff_pipe_stage.sv
// One WIDTH-bit register stage with asynchronous active-high reset to RST_VAL.
module dff_pipe_stage
    import dff_pipe_pkg::*;
#(
    parameter int unsigned     WIDTH   = DFF_PIPE_DEF_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Capture d every edge; reset overrides immediately without waiting for clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RST_VAL;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/dff_pipe.sv
// DEPTH-stage, WIDTH-bit register chain; dout is the last stage flop, DEPTH clocks behind din.
module dff_pipe
    import dff_pipe_pkg::*;
#(
    parameter int unsigned WIDTH   = DFF_PIPE_DEF_WIDTH,
    parameter int unsigned DEPTH   = DFF_PIPE_DEF_DEPTH,
    parameter              RST_VAL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    dff_pipe_if.slave  bus
);

    typedef logic [WIDTH-1:0] data_t;

    // Narrower reset values are zero-extended to the data width.
    localparam data_t RST_EXT = WIDTH'(RST_VAL);

    if (!chk_params(WIDTH, DEPTH, 32'($bits(RST_VAL)))) begin : g_bad_params
        $error("dff_pipe: illegal parameters WIDTH=%0d DEPTH=%0d RST_VAL bits=%0d",
               WIDTH, DEPTH, $bits(RST_VAL));
    end

    data_t stage_q [DEPTH];

    // Stage 0 takes din, every later stage takes its predecessor.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        data_t stage_d;

        if (i == 0) begin : g_first
            assign stage_d = bus.din;
        end else begin : g_next
            assign stage_d = stage_q[i-1];
        end

        dff_pipe_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_EXT)
        ) u_stage (
            .clk (clk),
            .rst (rst),
            .d   (stage_d),
            .q   (stage_q[i])
        );
    end

    assign bus.dout = stage_q[DEPTH-1];

`ifndef SYNTHESIS
    localparam int unsigned FILL_W = $clog2(DEPTH + 1);

    logic [FILL_W-1:0] fill;

    // Count edges since reset release, saturating at DEPTH, so the latency check arms only once the chain is full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill <= '0;
        end else if (fill != FILL_W'(DEPTH)) begin
            fill <= fill + FILL_W'(1);
        end
    end

    a_rst_val: assert property (@(posedge clk) rst |-> (bus.dout === RST_EXT))
        else $error("dff_pipe: dout not at reset value during reset");

    a_latency: assert property (@(posedge clk) disable iff (rst)
                                (fill == FILL_W'(DEPTH)) |-> (bus.dout === $past(bus.din, DEPTH)))
        else $error("dff_pipe: dout does not match din delayed by DEPTH edges");
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// Bench for dff_pipe: default 1-bit/1-stage instance and an 8-bit/3-stage instance with reset value A5.
module tb_dff_pipe;

    localparam int unsigned BW   = 8;
    localparam int unsigned BD   = 3;
    localparam logic [7:0]  BRST = 8'hA5;

    logic clk = 1'b0;
    logic rst;

    int checks   = 0;
    int failures = 0;

    dff_pipe_if #(.WIDTH(1))  ifa ();
    dff_pipe_if #(.WIDTH(BW)) ifb ();

    dff_pipe u_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    dff_pipe #(
        .WIDTH   (BW),
        .DEPTH   (BD),
        .RST_VAL (BRST)
    ) u_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    // 20 ns period, first rising edge at 10 ns.
    always #10 clk = ~clk;

    // Reference model: history of din values sampled since the last reset, at most DEPTH deep.
    logic       hist_a [$];
    logic [7:0] hist_b [$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_a.delete();
            hist_b.delete();
        end else begin
            hist_a.push_back(ifa.din);
            if (hist_a.size() > 1) void'(hist_a.pop_front());
            hist_b.push_back(ifb.din);
            if (hist_b.size() > BD) void'(hist_b.pop_front());
        end
    end

    function automatic logic [7:0] exp_a();
        return (hist_a.size() < 1) ? 8'h00 : {7'b0, hist_a[0]};
    endfunction

    function automatic logic [7:0] exp_b();
        return (hist_b.size() < BD) ? BRST : hist_b[0];
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_models(input string tag);
        check({tag, "_a_model"}, {7'b0, ifa.dout}, exp_a());
        check({tag, "_b_model"}, ifb.dout, exp_b());
    endtask

    logic [4:0] a_seq;
    logic [7:0] b_exp [5];

    initial begin
        a_seq = 5'b01101;
        b_exp = '{8'hA5, 8'hA5, 8'h01, 8'h02, 8'h03};

        // Reset hold with din toggling, including across the 10 ns edge.
        rst = 1'b1;
        ifa.din = 1'b0;
        ifb.din = 8'h00;
        #3;
        ifa.din = 1'b1;
        ifb.din = 8'h5A;
        #2;
        check("rst_hold_5_a", {7'b0, ifa.dout}, 8'h00);
        check("rst_hold_5_b", ifb.dout, BRST);
        @(posedge clk);
        #2;
        check("rst_hold_edge_a", {7'b0, ifa.dout}, 8'h00);
        check("rst_hold_edge_b", ifb.dout, BRST);
        #1;
        ifa.din = 1'b0;
        ifb.din = 8'h01;
        #7;
        ifa.din = 1'b1;
        check("rst_hold_20_a", {7'b0, ifa.dout}, 8'h00);
        #4;
        ifa.din = 1'b0;
        check("rst_hold_24_a", {7'b0, ifa.dout}, 8'h00);
        check_models("rst_hold");
        #1;
        rst = 1'b0;

        // Follow sequence; B shows A5,A5,01,02,03 on edges 1..5 after release.
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #2;
            if (k == 0) check("follow_a_first", {7'b0, ifa.dout}, 8'h00);
            else        check($sformatf("follow_a_%0d", k), {7'b0, ifa.dout}, {7'b0, a_seq[k-1]});
            check($sformatf("depth_b_%0d", k + 1), ifb.dout, b_exp[k]);
            check_models($sformatf("follow_%0d", k));
            #1;
            ifa.din = a_seq[k];
            ifb.din = 8'(k + 2);
        end

        // Asynchronous reset pulse between edges.
        #2;
        check("pre_pulse_a", {7'b0, ifa.dout}, 8'h01);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_a", {7'b0, ifa.dout}, 8'h00);
        check("async_rst_b", ifb.dout, BRST);
        check_models("async_rst");
        #4;
        rst = 1'b0;
        #1;
        ifa.din = 1'b1;
        @(posedge clk);
        #2;
        check("post_pulse_a", {7'b0, ifa.dout}, 8'h01);
        check("post_pulse_b", ifb.dout, BRST);
        check_models("post_pulse");

        // Steady input held for 10 cycles, then a single drop.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #2;
            check($sformatf("steady_early_%0d", i), {7'b0, ifa.dout}, 8'h01);
            #8;
            check($sformatf("steady_mid_%0d", i), {7'b0, ifa.dout}, 8'h01);
            check_models($sformatf("steady_%0d", i));
        end
        ifa.din = 1'b0;
        #5;
        check("drop_before_edge_a", {7'b0, ifa.dout}, 8'h01);
        @(posedge clk);
        #2;
        check("drop_after_edge_a", {7'b0, ifa.dout}, 8'h00);
        check_models("drop");

        // Random stress with occasional reset pulses that never span an edge.
        for (int n = 0; n < 1000; n++) begin
            @(posedge clk);
            #2;
            check_models("stress");
            #1;
            ifa.din = 1'($urandom);
            ifb.din = 8'($urandom);
            if ($urandom_range(0, 31) == 0) begin
                #2;
                rst = 1'b1;
                #1;
                check("stress_rst_a", {7'b0, ifa.dout}, 8'h00);
                check("stress_rst_b", ifb.dout, BRST);
                #2;
                rst = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200us;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
